// File: rtl/instruction_memory_pkg.sv
// Shared pipeline types for the rv32i core: the control word carried
// between pipeline stages.
package instruction_memory_pkg;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
    } rv32i_control_word;

endpackage

// File: rtl/instruction_memory.sv
// rv32i MEM stage: issues data-cache requests, aligns stores, extends loads
// and registers MEM/WB. Optional MEM_MISALIGN_TRAP_EN flags misaligned accesses.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  rv32i_control_word      ctrl_word_in,
    input  logic [31:0]            instruction_in,
    input  logic [31:0]            PC_in,
    input  logic [31:0]            alu_in,
    input  logic [31:0]            rs2_in,
    input  logic                   br_en_in,
    input  logic                   dmem_resp,
    input  logic [31:0]            dmem_rdata,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [31:0]            dmem_address,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_byte_enable,
    output logic                   stall_out,
    output rv32i_control_word      ctrl_word_out,
    output logic [31:0]            instruction_out,
    output logic [31:0]            PC_out,
    output logic [31:0]            alu_out,
    output logic [31:0]            mdr_out,
    output logic                   br_en_out,
    output logic                   misalign_out,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            mdr_d;
    logic                   capture;
    logic                   misalign_c;
    logic                   mem_op;
    logic [1:0]             off;
    logic [31:0]            ld_ext;
    logic [31:0]            byte_sh, half_sh;
    rv32i_control_word      ctrl_cap;

    rv32i_control_word      ctrl_q;
    logic [31:0]            instr_q, pc_q, alu_q, mdr_q;
    logic                   br_en_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign off          = alu_in[1:0];
    assign dmem_address = {alu_in[31:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    // Half accesses need an even offset, word accesses a zero offset
    always_comb begin
        misalign_c = 1'b0;
        if (ctrl_word_in.mem_read || ctrl_word_in.mem_write) begin
            case (ctrl_word_in.funct3[1:0])
                2'b01:   misalign_c = off[0];
                2'b10:   misalign_c = (off != 2'b00);
                default: misalign_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (capture) begin
            misalign_q <= misalign_c;
        end
    end

    assign misalign_out = misalign_q;
`else
    assign misalign_c   = 1'b0;
    assign misalign_out = 1'b0;
`endif

    assign mem_op = (ctrl_word_in.mem_read || ctrl_word_in.mem_write) && !misalign_c;

    // Store lane steering
    always_comb begin
        dmem_wdata       = rs2_in;
        dmem_byte_enable = 4'b1111;
        case (ctrl_word_in.funct3[1:0])
            2'b00: begin
                dmem_wdata       = rs2_in << {off, 3'b000};
                dmem_byte_enable = 4'b0001 << off;
            end
            2'b01: begin
                dmem_wdata       = rs2_in << {off[1], 4'b0000};
                dmem_byte_enable = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                dmem_wdata       = rs2_in;
                dmem_byte_enable = 4'b1111;
            end
        endcase
    end

    // Load extraction from the latched response word
    assign byte_sh = rdata_q >> {off, 3'b000};
    assign half_sh = rdata_q >> {off[1], 4'b0000};

    always_comb begin
        ld_ext = rdata_q;
        case (ctrl_word_in.funct3)
            3'b000:  ld_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  ld_ext = {24'd0, byte_sh[7:0]};
            3'b001:  ld_ext = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  ld_ext = {16'd0, half_sh[15:0]};
            default: ld_ext = rdata_q;
        endcase
    end

    always_comb begin
        ctrl_cap           = ctrl_word_in;
        ctrl_cap.mem_write = ctrl_word_in.mem_write && !misalign_c;
    end

    // Next-state, request and capture control
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        mdr_d      = 32'd0;
        capture    = 1'b0;
        stall_out  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d    = ACCESS;
                    stall_out  = 1'b1;
                    dmem_read  = ctrl_word_in.mem_read;
                    dmem_write = ctrl_word_in.mem_write;
                end else begin
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                stall_out = 1'b1;
                if (dmem_resp) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end else begin
                    dmem_read  = ctrl_word_in.mem_read;
                    dmem_write = ctrl_word_in.mem_write;
                end
            end
            DONE: begin
                capture = 1'b1;
                state_d = IDLE;
                if (ctrl_word_in.mem_read) begin
                    mdr_d = ld_ext;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset must kill an outstanding request without waiting for a clock
        if (rst) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            alu_q   <= 32'd0;
            mdr_q   <= 32'd0;
            br_en_q <= 1'b0;
        end else if (capture) begin
            ctrl_q  <= ctrl_cap;
            instr_q <= instruction_in;
            pc_q    <= PC_in;
            alu_q   <= alu_in;
            mdr_q   <= mdr_d;
            br_en_q <= br_en_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_out && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign ctrl_word_out   = ctrl_q;
    assign instruction_out = instr_q;
    assign PC_out          = pc_q;
    assign alu_out         = alu_q;
    assign mdr_out         = mdr_q;
    assign br_en_out       = br_en_q;
    assign stall_cycles    = stall_cnt_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed cases plus random
// loads, stores and ALU ops against an arithmetic reference model.
module tb_instruction_memory;
    import instruction_memory_pkg::*;

    localparam int unsigned STALL_CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    rv32i_control_word      ctrl_word_in;
    logic [31:0]            instruction_in, PC_in, alu_in, rs2_in;
    logic                   br_en_in;
    logic                   dmem_resp;
    logic [31:0]            dmem_rdata;
    logic                   dmem_read, dmem_write;
    logic [31:0]            dmem_address, dmem_wdata;
    logic [3:0]             dmem_byte_enable;
    logic                   stall_out;
    rv32i_control_word      ctrl_word_out;
    logic [31:0]            instruction_out, PC_out, alu_out, mdr_out;
    logic                   br_en_out, misalign_out;
    logic [STALL_CNT_W-1:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;
    int stall_model = 0;

    instruction_memory #(.STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ctrl_word_in(ctrl_word_in), .instruction_in(instruction_in),
        .PC_in(PC_in), .alu_in(alu_in), .rs2_in(rs2_in), .br_en_in(br_en_in),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .stall_out(stall_out),
        .ctrl_word_out(ctrl_word_out), .instruction_out(instruction_out),
        .PC_out(PC_out), .alu_out(alu_out), .mdr_out(mdr_out),
        .br_en_out(br_en_out), .misalign_out(misalign_out),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input int off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic rd, input logic wr, input logic [2:0] f3, input int off);
`ifdef MEM_MISALIGN_TRAP_EN
        if (!(rd || wr)) return 1'b0;
        if (f3[1:0] == 2'b01) return (off % 2) != 0;
        if (f3[1:0] == 2'b10) return off != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Presents one EX/MEM instruction at posedge+1 and follows it until MEM/WB captures it.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int lat, input logic bogus);
        rv32i_control_word cw, cw_exp;
        logic [31:0] instr, pc, exp_wdata, exp_mdr;
        logic [3:0]  exp_be;
        logic        br, mis;
        int          off;
        off = int'(alu % 4);
        cw = '0;
        cw.opcode       = rd ? 7'h03 : (wr ? 7'h23 : 7'h33);
        cw.funct3       = f3;
        cw.funct7       = 7'($urandom);
        cw.load_regfile = !wr;
        cw.mem_read     = rd;
        cw.mem_write    = wr;
        instr = $urandom;
        pc    = $urandom;
        br    = 1'($urandom);
        mis   = is_misaligned(rd, wr, f3, off);
        ctrl_word_in   = cw;
        instruction_in = instr;
        PC_in          = pc;
        alu_in         = alu;
        rs2_in         = rs2;
        br_en_in       = br;
        exp_mdr        = 32'd0;
        case (f3[1:0])
            2'b00: begin exp_wdata = rs2 << (8 * off);        exp_be = 4'(1 << off); end
            2'b01: begin exp_wdata = rs2 << (16 * (off / 2)); exp_be = 4'(3 << (2 * (off / 2))); end
            default: begin exp_wdata = rs2; exp_be = 4'hF; end
        endcase
        if ((rd || wr) && !mis) begin
            @(negedge clk);
            check("issue_stall", 32'(stall_out), 32'd1);
            check("issue_read", 32'(dmem_read), 32'(rd));
            check("issue_write", 32'(dmem_write), 32'(wr));
            check("address", dmem_address, alu & 32'hFFFF_FFFC);
            if (wr) begin
                check("wdata", dmem_wdata, exp_wdata);
                check("byte_en", 32'(dmem_byte_enable), 32'(exp_be));
            end
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #1;
                dmem_resp  = (k == lat);
                dmem_rdata = (k == lat) ? rdata : $urandom;
                @(negedge clk);
                check("access_stall", 32'(stall_out), 32'd1);
                check("access_read", 32'(dmem_read), (k == lat) ? 32'd0 : 32'(rd));
                check("access_write", 32'(dmem_write), (k == lat) ? 32'd0 : 32'(wr));
            end
            stall_model += 1 + lat;
            @(posedge clk); #1;
            dmem_resp  = 1'b0;
            dmem_rdata = $urandom;
            @(negedge clk);
            check("done_stall", 32'(stall_out), 32'd0);
            check("done_req", 32'({dmem_read, dmem_write}), 32'd0);
            if (rd) exp_mdr = load_model(f3, off, rdata);
        end else begin
            dmem_resp  = bogus;
            dmem_rdata = $urandom;
            @(negedge clk);
            check("pass_stall", 32'(stall_out), 32'd0);
            check("pass_req", 32'({dmem_read, dmem_write}), 32'd0);
        end
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        cw_exp = cw;
        cw_exp.mem_write = wr && !mis;
        check("ctrl_out", 32'(ctrl_word_out), 32'(cw_exp));
        check("instr_out", instruction_out, instr);
        check("pc_out", PC_out, pc);
        check("alu_out", alu_out, alu);
        check("mdr_out", mdr_out, exp_mdr);
        check("br_en_out", 32'(br_en_out), 32'(br));
        check("misalign_out", 32'(misalign_out), 32'(mis));
        check("stall_cycles", 32'(stall_cycles), 32'(stall_model > 65535 ? 65535 : stall_model));
    endtask

    initial begin
        rst = 1'b1;
        ctrl_word_in = '0;
        instruction_in = 32'd0; PC_in = 32'd0; alu_in = 32'd0; rs2_in = 32'd0;
        br_en_in = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'd0;
        #2;
        check("rst_alu", alu_out, 32'd0);
        check("rst_cnt", 32'(stall_cycles), 32'd0);
        check("rst_read", 32'(dmem_read), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ALU op: no request, result one edge later
        run_op(1'b0, 1'b0, 3'b000, 32'h55, $urandom, 32'd0, 0, 1'b1);

        // Reset while a load is waiting on the cache
        ctrl_word_in = '0;
        ctrl_word_in.mem_read = 1'b1;
        ctrl_word_in.funct3 = 3'b010;
        alu_in = 32'h100;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_access_read", 32'(dmem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_read", 32'(dmem_read), 32'd0);
        check("rst_mid_alu", alu_out, 32'd0);
        check("rst_mid_pc", PC_out, 32'd0);
        check("rst_mid_cnt", 32'(stall_cycles), 32'd0);
        ctrl_word_in = '0;
        stall_model = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        dmem_resp = 1'b1;
        @(negedge clk);
        check("stale_resp_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;

        // Back-to-back lw then sw, single-cycle cache
        run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 32'hCAFE_F00D, 1, 1'b0);
        run_op(1'b0, 1'b1, 3'b010, 32'h404, 32'h1234_5678, 32'd0, 1, 1'b0);
        check("b2b_cnt", 32'(stall_cycles), 32'd4);

        // Directed alignment cases
        run_op(1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'd0, 3, 1'b0);
        run_op(1'b1, 1'b0, 3'b000, 32'h2002, 32'd0, 32'h1280_FF34, 2, 1'b0);
        run_op(1'b1, 1'b0, 3'b100, 32'h2002, 32'd0, 32'h1280_FF34, 2, 1'b0);
        run_op(1'b1, 1'b0, 3'b101, 32'h2002, 32'd0, 32'h1280_FF34, 1, 1'b0);
        run_op(1'b1, 1'b0, 3'b001, 32'h2002, 32'd0, 32'h8001_0000, 1, 1'b0);
        run_op(1'b1, 1'b0, 3'b010, 32'h3001, 32'd0, 32'hDEAD_BEEF, 2, 1'b0);
        run_op(1'b0, 1'b1, 3'b001, 32'h3002, 32'hABCD_1234, 32'd0, 1, 1'b0);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [2:0] f3;
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            run_op(kind == 1, kind == 2, f3, $urandom, $urandom, $urandom,
                   $urandom_range(1, 4), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
